// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing a + b + cin, one bit per clock, LSB first.
// A single full-adder cell and a carry flip-flop do the arithmetic; operands shift out
// of their registers and sum bits shift into a result register from the MSB side.
// Build option: define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow
// output ovf.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      synchronous reset, active low
//   start  in   1      request; sampled only while ready=1
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry in, captured on the accepting edge
//   ready  out  1      high in IDLE or DONE (start will be accepted)
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse: sum/cout just updated
//   sum    out  WIDTH  registered result, held between completions
//   cout   out  1      registered carry out, held between completions
//   ovf    out  1      (SERIAL_ADDER_OVERFLOW_EN only) two's-complement overflow, held like sum

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    // One extra count value so that WIDTH=1 still yields a legal 1-bit counter.
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;

    logic              bit_s;
    logic              carry_d;
    logic [WIDTH-1:0]  res_d;

    // Full-adder cell on the current LSBs; new sum bit enters the result at the MSB.
    always_comb begin
        bit_s          = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d        = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        res_d          = res_q >> 1;
        res_d[WIDTH-1] = bit_s;
    end

    assign ready = (state_q != StRun);
    assign busy  = (state_q == StRun);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        sum     <= res_d;
                        cout    <= carry_d;
                        done    <= 1'b1;
                        state_q <= StDone;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // carry_q is the carry into the MSB at this edge.
                        ovf     <= carry_q ^ carry_d;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       ready8, busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1, a1, b1, cin1;
    logic       ready1, busy1, done1, cout1;
    logic [0:0] sum1;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf8, ovf1;
`endif

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .ready (ready1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .ovf   (ovf1)
`endif
    );

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t       q8[$];
    logic [1:0] q1[$];
    exp_t       mon_e;
    logic [1:0] mon_e1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] full;
        logic [7:0] low;
        exp_t r;
        full   = {1'b0, x} + {1'b0, y} + {8'd0, c};
        low    = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'd0, c};
        r.sum  = full[7:0];
        r.cout = full[8];
        r.ovf  = low[7] ^ full[8];
        return r;
    endfunction

    // Scoreboard monitors: each done pulse consumes one expected result.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("dut8_unexpected_done", q8.size(), 1);
            end else begin
                mon_e = q8.pop_front();
                check("dut8_sum", {24'd0, sum8}, {24'd0, mon_e.sum});
                check("dut8_cout", {31'd0, cout8}, {31'd0, mon_e.cout});
`ifdef SERIAL_ADDER_OVERFLOW_EN
                check("dut8_ovf", {31'd0, ovf8}, {31'd0, mon_e.ovf});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", q1.size(), 1);
            end else begin
                mon_e1 = q1.pop_front();
                check("dut1_cout_sum", {30'd0, cout1, sum1}, {30'd0, mon_e1});
            end
        end
    end

    task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic c);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        q8.push_back(model8(x, y, c));
    endtask

    // Counts falling edges until done is seen, bounded.
    task automatic wait_done8(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done8 !== 1'b1 && lat < 40);
        if (done8 !== 1'b1) check({tag, "_timeout"}, {31'd0, done8}, 1);
    endtask

    task automatic wait_done1(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done1 !== 1'b1 && lat < 20);
        if (done1 !== 1'b1) check({tag, "_timeout"}, {31'd0, done1}, 1);
    endtask

    initial begin
        int lat;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        cin1   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sum", {24'd0, sum8}, 0);
        check("rst_cout", {31'd0, cout8}, 0);
        check("rst_done", {31'd0, done8}, 0);
        check("rst_busy", {31'd0, busy8}, 0);
        check("rst_ready", {31'd0, ready8}, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 0x5A + 0x33: busy from E0 through the edge before E8, done after E8.
        start8(8'h5A, 8'h33, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t1_busy", {31'd0, busy8}, 1);
            check("t1_ready", {31'd0, ready8}, 0);
            check("t1_no_done", {31'd0, done8}, 0);
        end
        @(negedge clk);
        check("t1_done", {31'd0, done8}, 1);
        check("t1_busy_off", {31'd0, busy8}, 0);
        @(negedge clk);
        check("t1_done_pulse", {31'd0, done8}, 0);
        check("t1_sum_held", {24'd0, sum8}, 32'h8D);

        // Carry propagation extremes.
        start8(8'hFF, 8'h01, 1'b0);
        wait_done8("t2a", lat);
        check("t2a_latency", lat, 9);
        start8(8'hFF, 8'hFF, 1'b1);
        wait_done8("t2b", lat);

        // Start while busy is ignored.
        start8(8'h10, 8'h20, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done8("t3", lat);
        check("t3_latency", lat, 6);
        repeat (12) @(negedge clk);
        check("t3_idle", {31'd0, ready8}, 1);

        // Reset at E4 aborts the operation.
        start8(8'h55, 8'h0F, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t4_sum", {24'd0, sum8}, 0);
        check("t4_cout", {31'd0, cout8}, 0);
        check("t4_done", {31'd0, done8}, 0);
        check("t4_busy", {31'd0, busy8}, 0);
        check("t4_ready", {31'd0, ready8}, 1);
        q8.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Back-to-back with start held high.
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        q8.push_back(model8(8'h01, 8'h02, 1'b0));
        a = 8'h80;
        b = 8'h80;
        q8.push_back(model8(8'h80, 8'h80, 1'b0));
        wait_done8("t5a", lat);
        check("t5a_latency", lat, 9);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done8("t5b", lat);
        check("t5_done_gap", lat, 9);

        // Signed-overflow cases (ovf compared only when the option is built in).
        start8(8'h7F, 8'h01, 1'b0);
        wait_done8("t7a", lat);
        start8(8'hFF, 8'h01, 1'b0);
        wait_done8("t7b", lat);

        // WIDTH=1 full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v      = 3'(i);
            a1     = v[2];
            b1     = v[1];
            cin1   = v[0];
            start1 = 1'b1;
            @(posedge clk);
            #1 start1 = 1'b0;
            q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            wait_done1("t6", lat);
            check("t6_latency", lat, 2);
        end

        repeat (4) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
